serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
//
// PURPOSE
//   Bit-serial N-bit subtractor: computes diff = a - b one bit per clock, LSB first,
//   using a single full-subtractor cell and a registered borrow.
//   Inverse arithmetic companion to the ripple full_adder datapath. Used where
//   area matters more than latency. Driven by a start/ready/done handshake.
//
// PARAMETERS
//   WIDTH   8   operand and result width in bits (>= 1)
//
// PORTS
//   clk         in   1      single clock, rising edge
//   rst         in   1      asynchronous, active-high reset
//   start       in   1      request a subtraction; sampled only when ready=1
//   a           in   WIDTH  minuend, captured on the accepting edge
//   b           in   WIDTH  subtrahend, captured on the accepting edge
//   ready       out  1      1 in IDLE: start will be accepted
//   done        out  1      one-cycle pulse: diff/borrow_out just updated
//   diff        out  WIDTH  a - b modulo 2^WIDTH
//   borrow_out  out  1      1 when a < b (unsigned)
//
// BEHAVIOUR
//   Reset (async, any time, incl. mid-operation):
//     state=IDLE, ready=1, done=0, diff=0, borrow_out=0.
//     Operand, shift and count registers are cleared. An in-flight operation is discarded.
//   FSM: IDLE -> RUN -> DONE -> IDLE.
//   IDLE:
//     On an edge with start=1: latch a,b into shift regs, borrow_r=0, cnt=0, go to RUN.
//     If start=0, stay in IDLE.
//   RUN (ready=0), each edge: bit i uses ai=a_sh[0], bi=b_sh[0], br=borrow_r.
//     d = ai ^ bi ^ br
//     borrow_r <= (~ai & bi) | (~(ai ^ bi) & br)
//     d is shifted into the MSB of the result shift reg.
//     a_sh and b_sh shift right by one. cnt increments.
//     When cnt == WIDTH-1: load diff <= final result, borrow_out <= final borrow,
//     go to DONE.
//   DONE (ready=0, done=1) for exactly one cycle, then IDLE on the next edge.
//   Latency: the accepting edge is E0. diff/borrow_out update on edge E(WIDTH).
//     done is high in the cycle after E(WIDTH).
//     The next start can be accepted at E(WIDTH+2). Throughput is 1 op per WIDTH+2 cycles.
//   diff and borrow_out change only on the edge entering DONE, or on reset.
//     They hold their values through IDLE and the whole of the next RUN.
//   start while ready=0 (RUN or DONE) is ignored. It is not queued.
//   a and b are don't-care except on the accepting edge.
//   Changing a or b during RUN must not affect the result.
//   WIDTH=1: one RUN cycle. cnt is a clog2-width counter, minimum 1 bit.
//   Arithmetic: the result equals the unsigned (a - b) mod 2^WIDTH.
//     borrow_out equals the final borrow out of bit WIDTH-1.
//
// TESTING (WIDTH=8 unless stated)
//   1. Reset: rst=1 -> ready=1, done=0, diff=0, borrow_out=0.
//      Release rst -> all outputs unchanged.
//   2. a=100, b=37, start pulse -> done after 8 edges; diff=63, borrow_out=0.
//      done is high for exactly 1 cycle.
//   3. Boundaries:
//      5-10  -> diff=251, borrow=1
//      0-1   -> diff=255, borrow=1
//      255-255 -> diff=0, borrow=0
//      0-0   -> diff=0, borrow=0
//   4. Start while busy: start a=9,b=4; during RUN pulse start with a=1,b=2
//      -> the second start is ignored; diff=5, borrow_out=0.
//   5. Reset mid-op: rst asserted at RUN bit 3 -> outputs zero immediately.
//      A new op 200-199 afterwards -> diff=1, borrow_out=0.
//   6. Back-to-back plus exhaustive: start held high continuously
//      -> ops accepted every 10 cycles.
//      WIDTH=4: all 256 a,b pairs match (a-b)&15 and a<b.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one full-subtractor cell with a registered borrow,
// LSB first, driven by a start/ready/done handshake.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] res_nxt;
  logic             borrow_r;
  logic             borrow_nxt;
  logic [CW-1:0]    cnt;
  logic             ai;
  logic             bi;
  logic             d;
  logic             last;
  logic             accept;

  assign ai     = a_sh[0];
  assign bi     = b_sh[0];
  assign d      = ai ^ bi ^ borrow_r;
  assign last   = (cnt == LAST);
  assign accept = (state == S_IDLE) && start;

  assign borrow_nxt = (~ai & bi) | (~(ai ^ bi) & borrow_r);

  // New difference bit enters at the MSB; also valid for WIDTH=1.
  assign res_nxt = (res_sh >> 1) | (WIDTH'(d) << (WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    done      = 1'b0;
    unique case (state)
      S_IDLE: begin
        ready = 1'b1;
        if (start) begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (last) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh       <= '0;
      b_sh       <= '0;
      res_sh     <= '0;
      borrow_r   <= 1'b0;
      cnt        <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else if (accept) begin
      a_sh     <= a;
      b_sh     <= b;
      res_sh   <= '0;
      borrow_r <= 1'b0;
      cnt      <= '0;
    end else if (state == S_RUN) begin
      a_sh     <= a_sh >> 1;
      b_sh     <= b_sh >> 1;
      res_sh   <= res_nxt;
      borrow_r <= borrow_nxt;
      cnt      <= cnt + CW'(1);
      // Outputs only move on the edge that enters DONE.
      if (last) begin
        diff       <= res_nxt;
        borrow_out <= borrow_nxt;
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: cycle model for WIDTH=8,
// directed literal cases and an exhaustive WIDTH=4 sweep.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ready;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;

  logic         start4;
  logic [3:0]   a4;
  logic [3:0]   b4;
  logic         ready4;
  logic         done4;
  logic [3:0]   diff4;
  logic         borrow4;

  int passed = 0;
  int total  = 0;
  bit chk_on = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .ready      (ready),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk        (clk),
    .rst        (rst),
    .start      (start4),
    .a          (a4),
    .b          (b4),
    .ready      (ready4),
    .done       (done4),
    .diff       (diff4),
    .borrow_out (borrow4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // Transaction-level model: an accepted op yields a-b after W edges,
  // done lasts one cycle, then ready returns.
  logic         m_ready  = 1'b1;
  logic         m_done   = 1'b0;
  logic [W-1:0] m_diff   = '0;
  logic         m_borrow = 1'b0;
  int           m_left   = 0;
  logic [W-1:0] m_a;
  logic [W-1:0] m_b;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ready  = 1'b1;
      m_done   = 1'b0;
      m_diff   = '0;
      m_borrow = 1'b0;
      m_left   = 0;
    end else if (m_ready && start) begin
      m_a     = a;
      m_b     = b;
      m_left  = W;
      m_ready = 1'b0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_diff   = m_a - m_b;
        m_borrow = (m_a < m_b);
        m_done   = 1'b1;
      end
    end else if (m_done) begin
      m_done  = 1'b0;
      m_ready = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("ready", ready, m_ready);
      check("done", done, m_done);
      check("diff", diff, m_diff);
      check("borrow", borrow_out, m_borrow);
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!ready) check("ready_timeout", 0, 1);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!done) check("done_timeout", 0, 1);
  endtask

  task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic [W-1:0] ed, input logic eb);
    int n;
    wait_ready();
    a     = va;
    b     = vb;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    wait_done(n);
    check("latency", n, W);
    check("lit_diff", diff, ed);
    check("lit_borrow", borrow_out, eb);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("ready_back", ready, 1);
  endtask

  initial begin
    int n;
    int cyc;
    int last_done;
    int ndone;
    rst    = 1'b1;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    start4 = 1'b0;
    a4     = '0;
    b4     = '0;
    #12;
    check("rst_ready", ready, 1);
    check("rst_done", done, 0);
    check("rst_diff", diff, 0);
    check("rst_borrow", borrow_out, 0);
    chk_on = 1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rel_ready", ready, 1);
    check("rel_diff", diff, 0);

    run_op(8'd100, 8'd37, 8'd63, 1'b0);
    run_op(8'd5, 8'd10, 8'd251, 1'b1);
    run_op(8'd0, 8'd1, 8'd255, 1'b1);
    run_op(8'd255, 8'd255, 8'd0, 1'b0);
    run_op(8'd0, 8'd0, 8'd0, 1'b0);

    // Start while busy is ignored.
    wait_ready();
    a     = 8'd9;
    b     = 8'd4;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    a     = 8'd1;
    b     = 8'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    check("busy_diff", diff, 5);
    check("busy_borrow", borrow_out, 0);
    @(negedge clk);

    // Reset in the middle of an operation.
    wait_ready();
    a     = 8'd77;
    b     = 8'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_diff", diff, 0);
    check("mid_rst_borrow", borrow_out, 0);
    check("mid_rst_ready", ready, 1);
    check("mid_rst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op(8'd200, 8'd199, 8'd1, 1'b0);

    // Start held high: one op every W+2 cycles.
    wait_ready();
    start     = 1'b1;
    cyc       = 0;
    last_done = -1;
    ndone     = 0;
    for (int i = 0; i < 62; i++) begin
      a = $urandom;
      b = $urandom;
      @(negedge clk);
      cyc++;
      if (done) begin
        ndone++;
        if (last_done >= 0) check("b2b_period", cyc - last_done, W + 2);
        last_done = cyc;
      end
    end
    start = 1'b0;
    check("b2b_count", ndone, 6);
    repeat (12) @(negedge clk);

    // Random start pattern and operands.
    for (int i = 0; i < 500; i++) begin
      start = ($urandom_range(0, 2) == 0);
      a     = $urandom;
      b     = $urandom;
      @(negedge clk);
    end
    start = 1'b0;
    repeat (12) @(negedge clk);

    // Exhaustive WIDTH=4.
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        n = 0;
        while (!ready4 && n < 20) begin
          @(negedge clk);
          n++;
        end
        a4     = 4'(x);
        b4     = 4'(y);
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        a4     = $urandom;
        b4     = $urandom;
        n      = 0;
        while (!done4 && n < 20) begin
          @(negedge clk);
          n++;
        end
        if (!done4) check("w4_timeout", 0, 1);
        check("w4_diff", diff4, 32'((x - y) & 15));
        check("w4_borrow", borrow4, (x < y) ? 1 : 0);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
